// File: rtl/ccm_loader_pkg.sv
// Shared types and constants for the CCM boot loader.
// FSM states, header size, and checksum seed.
package ccm_loader_pkg;

    typedef enum logic [2:0] {
        S_LEN,
        S_ADDR,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    localparam int         HDR_BYTES = 4;
    localparam logic [7:0] CSUM_SEED = 8'h00;

    function automatic logic is_busy(input state_t s);
        return (s == S_LEN) || (s == S_ADDR) || (s == S_DATA) || (s == S_CSUM);
    endfunction

endpackage

// File: rtl/ccm_ld_packer.sv
// Little-endian byte-to-word assembler; word_vld is combinational on the 4th accepted byte.
// No backpressure: take is the already-qualified byte transfer.
module ccm_ld_packer
    import ccm_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        take,
    input  logic [7:0]  byte_dat,
    output logic        word_vld,
    output logic [31:0] word_dat
);

    logic [1:0]  lane;
    logic [23:0] acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane <= 2'd0;
            acc  <= 24'd0;
        end else if (clr) begin
            lane <= 2'd0;
            acc  <= 24'd0;
        end else if (take) begin
            lane <= lane + 2'd1;
            case (lane)
                2'd0:    acc[7:0]   <= byte_dat;
                2'd1:    acc[15:8]  <= byte_dat;
                2'd2:    acc[23:16] <= byte_dat;
                default: ;
            endcase
        end
    end

    // The top lane is never stored: the word is presented while its last byte is on the bus.
    assign word_vld = take && (lane == 2'(HDR_BYTES - 1));
    assign word_dat = {byte_dat, acc};

endmodule

// File: rtl/ccm_loader.sv
// Framed byte-stream loader into CCM; each word is written one cycle after its 4th byte.
// Ready is high in every loading state (one byte per cycle), low once done or errored.
module ccm_loader
    import ccm_loader_pkg::*;
#(
    parameter int MAX_WORDS = 16384,
    parameter int RST_HOLD  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ld_byte_valid,
    input  logic [7:0]  ld_byte_data,
    output logic        ld_byte_ready,
    input  logic        ld_restart,
    output logic        mem_wr_en,
    output logic [31:0] mem_wr_addr,
    output logic [31:0] mem_wr_data,
    output logic        core_rst_n,
    output logic        ld_busy,
    output logic        ld_done,
    output logic        ld_err
);

    state_t      state, state_nxt;
    logic        accept;
    logic        pk_take;
    logic        word_vld;
    logic [31:0] word_dat;
    logic [29:0] len_q;
    logic [29:0] base_q;
    logic [29:0] word_idx;
    logic [7:0]  csum;
    logic [7:0]  hold_cnt;
    logic        last_word;

    // A byte coinciding with restart is dropped.
    assign accept    = ld_byte_valid && ld_byte_ready && !ld_restart;
    assign pk_take   = accept && (state == S_LEN || state == S_ADDR || state == S_DATA);
    assign last_word = (word_idx == len_q - 30'd1);

    ccm_ld_packer u_packer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (ld_restart),
        .take     (pk_take),
        .byte_dat (ld_byte_data),
        .word_vld (word_vld),
        .word_dat (word_dat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_LEN;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (ld_restart) begin
            state_nxt = S_LEN;
        end else begin
            case (state)
                S_LEN:  if (word_vld) state_nxt = (word_dat > 32'(MAX_WORDS)) ? S_ERR : S_ADDR;
                S_ADDR: if (word_vld) begin
                    if (word_dat[1:0] != 2'b00) state_nxt = S_ERR;
                    else if (len_q == 30'd0)    state_nxt = S_CSUM;
                    else                        state_nxt = S_DATA;
                end
                S_DATA: if (word_vld && last_word) state_nxt = S_CSUM;
                S_CSUM: if (accept) state_nxt = (ld_byte_data == csum) ? S_DONE : S_ERR;
                default: ;
            endcase
        end
    end

    // Status outputs are registered from the next state so they sit at zero through reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_byte_ready <= 1'b0;
            ld_busy       <= 1'b0;
            ld_done       <= 1'b0;
            ld_err        <= 1'b0;
            core_rst_n    <= 1'b0;
            hold_cnt      <= 8'd0;
        end else begin
            ld_byte_ready <= is_busy(state_nxt);
            ld_busy       <= is_busy(state_nxt);
            ld_done       <= (state_nxt == S_DONE);
            ld_err        <= (state_nxt == S_ERR);
            if (state == S_DONE && !ld_restart) begin
                if (int'(hold_cnt) < RST_HOLD) hold_cnt <= hold_cnt + 8'd1;
                core_rst_n <= (int'(hold_cnt) + 1 >= RST_HOLD);
            end else begin
                hold_cnt   <= 8'd0;
                core_rst_n <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q       <= 30'd0;
            base_q      <= 30'd0;
            word_idx    <= 30'd0;
            csum        <= CSUM_SEED;
            mem_wr_en   <= 1'b0;
            mem_wr_addr <= 32'd0;
            mem_wr_data <= 32'd0;
        end else begin
            mem_wr_en <= 1'b0;
            if (ld_restart) begin
                word_idx <= 30'd0;
                csum     <= CSUM_SEED;
            end else begin
                if (word_vld && state == S_LEN)  len_q  <= word_dat[29:0];
                if (word_vld && state == S_ADDR) base_q <= word_dat[31:2];
                if (accept && state == S_DATA)   csum   <= csum ^ ld_byte_data;
                if (word_vld && state == S_DATA) begin
                    mem_wr_en   <= 1'b1;
                    mem_wr_addr <= {2'b00, base_q} + {2'b00, word_idx};
                    mem_wr_data <= word_dat;
                    word_idx    <= word_idx + 30'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ccm_loader.sv
// Scoreboard bench for ccm_loader: stimulus pushes expected writes, a negedge monitor pops them.
module tb_ccm_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ld_byte_valid = 1'b0;
    logic [7:0]  ld_byte_data = 8'h00;
    logic        ld_byte_ready;
    logic        ld_restart = 1'b0;
    logic        mem_wr_en;
    logic [31:0] mem_wr_addr;
    logic [31:0] mem_wr_data;
    logic        core_rst_n;
    logic        ld_busy;
    logic        ld_done;
    logic        ld_err;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t        exp_q[$];
    wr_t        exp_w;
    logic [7:0] pay[$];
    int         n_pass = 0;
    int         n_total = 0;
    logic       prev_en = 1'b0;
    bit         gap_mode = 1'b0;
    int         byte_no = 0;

    localparam int MAX_WORDS = 16384;
    localparam int RST_HOLD  = 4;

    ccm_loader #(.MAX_WORDS(MAX_WORDS), .RST_HOLD(RST_HOLD)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ld_byte_valid (ld_byte_valid),
        .ld_byte_data  (ld_byte_data),
        .ld_byte_ready (ld_byte_ready),
        .ld_restart    (ld_restart),
        .mem_wr_en     (mem_wr_en),
        .mem_wr_addr   (mem_wr_addr),
        .mem_wr_data   (mem_wr_data),
        .core_rst_n    (core_rst_n),
        .ld_busy       (ld_busy),
        .ld_done       (ld_done),
        .ld_err        (ld_err)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: every write strobe must match the next expected write and last one cycle.
    always @(negedge clk) begin
        if (rst_n && mem_wr_en) begin
            chk("wr_pulse_width", 72'(prev_en), 72'(0));
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_write: got addr=%0h data=%0h expected no write",
                         mem_wr_addr, mem_wr_data);
            end else begin
                exp_w = exp_q.pop_front();
                chk("write", 72'({mem_wr_addr, mem_wr_data}), 72'(exp_w));
            end
        end
        prev_en = rst_n && mem_wr_en;
    end

    task automatic push(input logic [31:0] a, input logic [31:0] d);
        exp_q.push_back('{addr: a, data: d});
    endtask

    // Entered and left at posedge+1.
    task automatic send_b(input logic [7:0] b);
        bit acc;
        int gap;
        gap = gap_mode ? (byte_no % 3) : 0;
        byte_no++;
        for (int i = 0; i < gap; i++) begin
            ld_byte_valid = 1'b0;
            @(posedge clk); #1;
        end
        ld_byte_valid = 1'b1;
        ld_byte_data  = b;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            acc = ld_byte_ready;
            @(posedge clk); #1;
            if (acc) return;
        end
        n_total++;
        $display("FAIL byte_timeout: byte %0h not accepted, expected accept within 50 cycles", b);
    endtask

    task automatic send_w(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_b(w[8*i +: 8]);
    endtask

    task automatic send_frame(input logic [31:0] len, input logic [31:0] base, input logic [7:0] cs);
        send_w(len);
        send_w(base);
        foreach (pay[i]) send_b(pay[i]);
        send_b(cs);
        ld_byte_valid = 1'b0;
    endtask

    // Status order: {ready, busy, done, err, core_rst_n}. Consumes one cycle.
    task automatic st(input string name, input logic [4:0] exp);
        @(negedge clk);
        chk(name, 72'({ld_byte_ready, ld_busy, ld_done, ld_err, core_rst_n}), 72'(exp));
        @(posedge clk); #1;
    endtask

    task automatic do_restart(input bit with_byte);
        ld_restart    = 1'b1;
        ld_byte_valid = with_byte;
        ld_byte_data  = 8'h99;
        @(posedge clk); #1;
        ld_restart    = 1'b0;
        ld_byte_valid = 1'b0;
        st("after_restart", 5'b11000);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk(name, 72'({ld_byte_ready, mem_wr_en, mem_wr_addr, mem_wr_data,
                       core_rst_n, ld_busy, ld_done, ld_err}), 72'(0));
    endtask

    task automatic nominal_frame();
        push(32'h40, 32'h4433_2211);
        push(32'h41, 32'h8877_6655);
        pay = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        send_frame(32'd2, 32'h0000_0100, 8'h88);
    endtask

    initial begin
        // Reset state and first edge after release.
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset_outputs");
        rst_n = 1'b1;
        @(posedge clk); #1;
        st("post_reset", 5'b11000);

        // Nominal back-to-back load, core release after RST_HOLD, stray byte ignored.
        nominal_frame();
        for (int i = 0; i < RST_HOLD; i++) st("done_hold", 5'b00100);
        st("core_released", 5'b00101);
        ld_byte_valid = 1'b1;
        ld_byte_data  = 8'hEE;
        st("stray_byte", 5'b00101);
        st("stray_byte", 5'b00101);
        ld_byte_valid = 1'b0;
        do_restart(1'b0);

        // Bad checksum: both writes still happen, then error.
        push(32'h40, 32'h4433_2211);
        push(32'h41, 32'h8877_6655);
        pay = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        send_frame(32'd2, 32'h0000_0100, 8'h00);
        for (int i = 0; i < RST_HOLD + 2; i++) st("bad_csum", 5'b00010);
        do_restart(1'b0);

        // Misaligned base: error right after the 8th byte.
        send_w(32'd2);
        send_w(32'h0000_0102);
        ld_byte_valid = 1'b0;
        st("misaligned", 5'b00010);
        do_restart(1'b0);

        // Empty payload.
        pay = {};
        send_frame(32'd0, 32'd0, 8'h00);
        st("len_zero", 5'b00100);
        do_restart(1'b0);

        // Oversized length.
        send_w(32'(MAX_WORDS + 1));
        ld_byte_valid = 1'b0;
        st("len_too_big", 5'b00010);
        do_restart(1'b0);

        // Same nominal frame with valid gaps.
        gap_mode = 1'b1;
        nominal_frame();
        gap_mode = 1'b0;
        st("gap_done", 5'b00100);
        do_restart(1'b0);

        // Restart after 5 payload bytes; the dropped 0x99 must not disturb the new frame.
        push(32'h40, 32'h4433_2211);
        send_w(32'd2);
        send_w(32'h0000_0100);
        send_b(8'h11); send_b(8'h22); send_b(8'h33); send_b(8'h44); send_b(8'h55);
        do_restart(1'b1);
        push(32'h80, 32'hDDCC_BBAA);
        pay = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        send_frame(32'd1, 32'h0000_0200, 8'h00);
        st("restart_new_frame", 5'b00100);
        do_restart(1'b0);

        // Async reset while a write strobe is high: outputs clear without a clock edge.
        send_w(32'd1);
        send_w(32'h0000_0300);
        send_b(8'h01); send_b(8'h02); send_b(8'h03); send_b(8'h04);
        ld_byte_valid = 1'b0;
        chk("wr_before_async_rst", 72'({mem_wr_en, mem_wr_addr, mem_wr_data}),
            72'({1'b1, 32'h0000_00C0, 32'h0403_0201}));
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_reset_outputs");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        st("post_async_reset", 5'b11000);
        pay = {};
        send_frame(32'd0, 32'd0, 8'h00);
        st("clean_after_reset", 5'b00100);

        repeat (3) @(posedge clk);
        chk("queue_empty", 72'(exp_q.size()), 72'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ccm_loader.md
Name: ccm_loader

Overview:
- Boot-time program loader and initiator on the CCM write side; the core only reads ICCM.
- Accepts a framed little-endian byte stream, packs it into 32-bit words and writes them into ICCM/DCCM through a single-cycle write port.
- Holds the rv32i_x core in reset until a frame is loaded and its checksum passes.
- Sits in the top-level wrapper between the debug/UART byte source and the CCM write mux.

Parameters:
MAX_WORDS, 16384, largest accepted payload length in words; a larger length is an error.
RST_HOLD, 4, cycles core_rst_n stays low after entering S_DONE before release.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
ld_byte_valid  input  1  source has a byte
ld_byte_data  input  8  stream byte
ld_byte_ready  output  1  loader accepts byte; transfer = valid & ready
ld_restart  input  1  one-cycle pulse: abort or re-arm, return to S_LEN
mem_wr_en  output  1  one-cycle write strobe
mem_wr_addr  output  32  word address {2'b00, byte_addr[31:2]}
mem_wr_data  output  32  packed word, first byte in [7:0]
core_rst_n  output  1  core reset, low while loading
ld_busy  output  1  high in S_LEN/S_ADDR/S_DATA/S_CSUM
ld_done  output  1  high in S_DONE
ld_err  output  1  high in S_ERR

Behaviour:
- Reset values: ld_byte_ready=0, mem_wr_en=0, mem_wr_addr=0, mem_wr_data=0, core_rst_n=0, ld_busy=0, ld_done=0, ld_err=0. State=S_LEN; outputs take S_LEN values on the first clock edge after reset release.
- Frame format:
  - 4-byte word count LEN, little-endian.
  - 4-byte base byte address BASE, little-endian.
  - LEN*4 payload bytes.
  - 1 checksum byte equal to the XOR of all payload bytes.
- FSM:
  - S_LEN: collect 4 bytes. If LEN > MAX_WORDS go to S_ERR, else go to S_ADDR.
  - S_ADDR: collect 4 bytes. If BASE[1:0] != 0 go to S_ERR. Else go to S_DATA, or to S_CSUM if LEN == 0.
  - S_DATA: pack bytes into a word.
  - S_CSUM: compare one byte. Match goes to S_DONE, mismatch goes to S_ERR.
  - S_DONE: terminal until ld_restart.
  - S_ERR: terminal until ld_restart.
- Handshake:
  - ld_byte_ready = 1 in S_LEN/S_ADDR/S_DATA/S_CSUM, 0 in S_DONE/S_ERR.
  - The loader never stalls inside those states, so one byte can be accepted every cycle.
- Packing: a 2-bit byte counter selects the lane.
- Write timing:
  - On the cycle the 4th byte of a word is accepted, the word is registered.
  - The following cycle, mem_wr_en=1 for exactly one cycle, with mem_wr_addr = {2'b00, BASE[31:2]} + word_idx.
  - word_idx increments after each write and wraps modulo 2^30; no overflow check.
- The running checksum XORs only payload bytes; the checksum is 0 at S_LEN entry.
- After the last payload word is accepted, the state moves to S_CSUM. The last write issues in parallel, in the first S_CSUM cycle.
- S_DONE:
  - core_rst_n rises RST_HOLD cycles after entry and stays high.
  - A stray byte is not accepted because ready=0.
- S_ERR: core_rst_n stays 0.
- ld_restart:
  - In any state, the next state is S_LEN.
  - Byte counter, word_idx and checksum clear, and core_rst_n is driven 0 next cycle.
  - A byte presented in the same cycle as ld_restart is dropped (not counted).
  - A pending mem_wr_en from the previous cycle still completes.
- Asynchronous reset mid-frame: the partial frame is discarded and all outputs take their reset values immediately.

Decomposition:
- Package ccm_loader_pkg:
  - state enum S_LEN/S_ADDR/S_DATA/S_CSUM/S_DONE/S_ERR.
  - HDR_BYTES=4.
  - Checksum seed 8'h00.
- Sub-module ccm_ld_packer:
  - byte-to-word assembler: lane counter, 32-bit shift/insert register, word_valid pulse.
  - Used for LEN, BASE and payload.

Test Plan:
- Nominal load: LEN=2, BASE=0x0000_0100, bytes 11 22 33 44 55 66 77 88, csum=0x88 -> writes (0x40, 0x44332211) then (0x41, 0x88776655). ld_done=1, core_rst_n=1 after RST_HOLD cycles.
- Bad checksum: same frame with csum=0x00 -> both writes occur, ld_err=1, core_rst_n stays 0, ready=0.
- Misaligned BASE=0x0000_0102 -> S_ERR right after 8th byte, no mem_wr_en ever.
- LEN=0, BASE=0, csum=0x00 -> no writes, ld_done=1. LEN=MAX_WORDS+1 -> ld_err after 4th byte.
- Back-to-back valid every cycle, plus random valid gaps -> identical write sequence, each mem_wr_en exactly one cycle.
- ld_restart mid-payload after 5 bytes, then a full new frame -> only words from the new frame written (plus at most the one pending write). rst_n pulse mid-frame -> all outputs return to reset values asynchronously.
